pipe_stage_buf: RTL and testbench

Parametrised pipeline-register stage with a valid/ready handshake, a two-entry skid buffer, stall and flush controls, and bubble insertion. It replaces the fixed-width, always-capture IF/ID, ID/EX, EX/MEM and MEM/WB registers. Each CPU stage boundary instantiates one copy, sized for its payload and control bus. Unlike those registers, it can hold data under back-pressure, squash in-flight instructions, and emit a NOP control word whenever it has no valid output.

---
 rtl/pipe_stage_buf.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Pipeline-register stage with valid/ready handshake, optional
//            two-entry skid buffer, stall/flush and NOP bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int                  DATA_W      = 96,
    parameter int                  CTRL_W      = 12,
    parameter logic [CTRL_W-1:0]   BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter bit                  SKID_EN     = 1'b1,
    parameter int                  CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              stall,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic w_m_valid;
    logic w_s_valid;
    logic w_block;
    logic w_accept;
    logic w_issue;

    assign w_m_valid = (state_q != ST_EMPTY);
    assign w_s_valid = (state_q == ST_FULL);
    assign w_block   = stall | flush;
    assign w_accept  = in_valid & in_ready;
    assign w_issue   = out_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            m_data_q <= '0;
            m_ctrl_q <= BUBBLE_CTRL;
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_data_q <= '0;
                    s_ctrl_q <= BUBBLE_CTRL;
                end else begin
                    s_data_q <= s_data_d;
                    s_ctrl_q <= s_ctrl_d;
                end
            end
        end else begin : g_no_skid
            assign s_data_q = '0;
            assign s_ctrl_q = BUBBLE_CTRL;
        end
    endgenerate

    // Next-state logic; flush squashes validity but leaves data registers alone
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d  = ST_BUSY;
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                    end
                end
                ST_BUSY: begin
                    if (w_accept && w_issue) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                    end else if (w_accept) begin
                        if (SKID_EN) begin
                            state_d  = ST_FULL;
                            s_data_d = in_data;
                            s_ctrl_d = in_ctrl;
                        end
                    end else if (w_issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_issue) begin
                        state_d  = ST_BUSY;
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output decode; rst_n gates in_ready so nothing is accepted during reset
    always_comb begin
        out_valid = w_m_valid & ~w_block;
        out_data  = m_data_q;
        out_ctrl  = out_valid ? m_ctrl_q : BUBBLE_CTRL;
        if (SKID_EN) begin
            in_ready = ~w_s_valid & ~w_block & rst_n;
        end else begin
            in_ready = (~w_m_valid | out_ready) & ~w_block & rst_n;
        end
        occupancy = {1'b0, w_m_valid} + {1'b0, w_s_valid};
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            bubble_cnt_d = '0;
        end else if (out_ready && !out_valid && !stall && !(&bubble_cnt_q)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : Self-checking bench for pipe_stage_buf, skid and non-skid builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int NW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0, cnt_clr = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl;
    assign in_ctrl = {1'b1, in_data[2:0]};

    logic [1:0]          ir, ov;
    logic [1:0][DW-1:0]  od;
    logic [1:0][CW-1:0]  oc;
    logic [1:0][1:0]     occ;
    logic [1:0][NW-1:0]  bc;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(4'h0), .SKID_EN(1'b1), .CNT_W(NW)) u_skid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .out_ctrl(oc[0]), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(occ[0]), .bubble_cnt(bc[0]));

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(4'h0), .SKID_EN(1'b0), .CNT_W(NW)) u_noskid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .out_ctrl(oc[1]), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .occupancy(occ[1]), .bubble_cnt(bc[1]));

    int total = 0;
    int bad   = 0;

    // Reference model: a bounded FIFO per DUT plus a saturating counter
    int            mcnt [2];
    logic [DW-1:0] mq   [2][2];
    int            mb   [2];
    bit            sk   [2] = '{1'b1, 1'b0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit e_ir(int k);
        return rst_n && !stall && !flush && (sk[k] ? (mcnt[k] < 2) : (mcnt[k] == 0 || out_ready));
    endfunction

    function automatic bit e_ov(int k);
        return (mcnt[k] > 0) && !stall && !flush;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mb[k]   = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_in_ready", k), 32'(ir[k]), 32'(e_ir(k)));
            chk($sformatf("d%0d_out_valid", k), 32'(ov[k]), 32'(e_ov(k)));
            if (e_ov(k)) chk($sformatf("d%0d_out_data", k), 32'(od[k]), 32'(mq[k][0]));
            chk($sformatf("d%0d_out_ctrl", k), 32'(oc[k]),
                e_ov(k) ? 32'({1'b1, mq[k][0][2:0]}) : 32'h0);
            chk($sformatf("d%0d_occupancy", k), 32'(occ[k]), 32'(mcnt[k]));
            chk($sformatf("d%0d_bubble_cnt", k), 32'(bc[k]), 32'(mb[k]));
        end
    endtask

    task automatic model_update();
        bit acc, iss, nov;
        for (int k = 0; k < 2; k++) begin
            acc = in_valid && e_ir(k);
            iss = e_ov(k) && out_ready;
            nov = !e_ov(k);
            if (cnt_clr) mb[k] = 0;
            else if (out_ready && nov && !stall && mb[k] < (2**NW - 1)) mb[k]++;
            if (flush) begin
                mcnt[k] = 0;
            end else begin
                if (iss) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (acc) begin
                    mq[k][mcnt[k]] = in_data;
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic apply(input bit iv, input logic [DW-1:0] d, input bit ordy,
                         input bit st, input bit fl, input bit clr);
        in_valid = iv; in_data = d; out_ready = ordy; stall = st; flush = fl; cnt_clr = clr;
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit iv; logic [DW-1:0] d; bit ordy; bit st; bit fl;
        bit eir; bit eov; logic [DW-1:0] eod; int eocc;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset/first accept, back-pressure 1..6, flush while FULL, stall in BUSY
        tbl.push_back('{1, 16'hA5, 1, 0, 0, 1, 0, 16'h00, 0});
        tbl.push_back('{0, 16'h00, 1, 0, 0, 1, 1, 16'hA5, 1});
        tbl.push_back('{1, 16'h01, 1, 0, 0, 1, 0, 16'hA5, 0});
        tbl.push_back('{1, 16'h02, 0, 0, 0, 1, 1, 16'h01, 1});
        tbl.push_back('{1, 16'h03, 0, 0, 0, 0, 1, 16'h01, 2});
        tbl.push_back('{1, 16'h03, 1, 0, 0, 0, 1, 16'h01, 2});
        tbl.push_back('{1, 16'h03, 1, 0, 0, 1, 1, 16'h02, 1});
        tbl.push_back('{1, 16'h04, 1, 0, 0, 1, 1, 16'h03, 1});
        tbl.push_back('{1, 16'h05, 1, 0, 0, 1, 1, 16'h04, 1});
        tbl.push_back('{1, 16'h06, 1, 0, 0, 1, 1, 16'h05, 1});
        tbl.push_back('{0, 16'h00, 1, 0, 0, 1, 1, 16'h06, 1});
        tbl.push_back('{0, 16'h00, 1, 0, 0, 1, 0, 16'h06, 0});
        tbl.push_back('{1, 16'h11, 0, 0, 0, 1, 0, 16'h06, 0});
        tbl.push_back('{1, 16'h22, 0, 0, 0, 1, 1, 16'h11, 1});
        tbl.push_back('{0, 16'h00, 1, 0, 1, 0, 0, 16'h11, 2});
        tbl.push_back('{0, 16'h00, 1, 0, 0, 1, 0, 16'h11, 0});
        tbl.push_back('{1, 16'h33, 1, 0, 0, 1, 0, 16'h11, 0});
        tbl.push_back('{1, 16'h44, 1, 1, 0, 0, 0, 16'h33, 1});
        tbl.push_back('{1, 16'h44, 1, 1, 0, 0, 0, 16'h33, 1});
        tbl.push_back('{1, 16'h44, 1, 1, 0, 0, 0, 16'h33, 1});
        tbl.push_back('{0, 16'h00, 1, 0, 0, 1, 1, 16'h33, 1});
        tbl.push_back('{0, 16'h00, 1, 0, 0, 1, 0, 16'h33, 0});

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_in_ready", k), 32'(ir[k]), 32'h0);
            chk($sformatf("rst%0d_out_valid", k), 32'(ov[k]), 32'h0);
            chk($sformatf("rst%0d_out_data", k), 32'(od[k]), 32'h0);
            chk($sformatf("rst%0d_out_ctrl", k), 32'(oc[k]), 32'h0);
            chk($sformatf("rst%0d_occupancy", k), 32'(occ[k]), 32'h0);
            chk($sformatf("rst%0d_bubble_cnt", k), 32'(bc[k]), 32'h0);
        end
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].st, tbl[i].fl, 1'b0);
            chk($sformatf("tbl%0d_in_ready", i), 32'(ir[0]), 32'(tbl[i].eir));
            chk($sformatf("tbl%0d_out_valid", i), 32'(ov[0]), 32'(tbl[i].eov));
            chk($sformatf("tbl%0d_out_data", i), 32'(od[0]), 32'(tbl[i].eod));
            chk($sformatf("tbl%0d_out_ctrl", i), 32'(oc[0]),
                tbl[i].eov ? 32'({1'b1, tbl[i].eod[2:0]}) : 32'h0);
            chk($sformatf("tbl%0d_occupancy", i), 32'(occ[0]), 32'(tbl[i].eocc));
            tick();
        end

        // Starvation counter: clear, then 20 starved cycles saturate at 15
        apply(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        repeat (20) begin
            apply(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("sat_skid", 32'(bc[0]), 32'd15);
        chk("sat_noskid", 32'(bc[1]), 32'd15);
        apply(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_skid", 32'(bc[0]), 32'd0);
        chk("clr_noskid", 32'(bc[1]), 32'd0);

        // Continuous stream with out_ready toggling every cycle
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 16'(16'h100 + i), 1'(i % 2), 1'b0, 1'b0, 1'b0);
            if (mcnt[1] == 1) chk("noskid_ready_tracks", 32'(ir[1]), 32'(out_ready));
            chk("noskid_occ_le1", 32'(occ[1] <= 2'd1), 32'h1);
            tick();
        end
        repeat (3) begin
            apply(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Randomised traffic with one mid-operation reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
                rst_n = 1'b0;
                #1;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("mid%0d_out_valid", k), 32'(ov[k]), 32'h0);
                    chk($sformatf("mid%0d_out_ctrl", k), 32'(oc[k]), 32'h0);
                    chk($sformatf("mid%0d_out_data", k), 32'(od[k]), 32'h0);
                    chk($sformatf("mid%0d_occupancy", k), 32'(occ[k]), 32'h0);
                    chk($sformatf("mid%0d_in_ready", k), 32'(ir[k]), 32'h0);
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            apply(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0,
                  ($urandom % 16) == 0, ($urandom % 32) == 0, ($urandom % 64) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
